// File: rtl/multiplicador_secuencial_pkg.sv
// Shared types and helpers for the shift-and-add sequential multiplier.
// Holds the controller state encoding and the iteration counter width rule.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } estado_t;

    // One extra bit over $clog2 keeps the count BITS-1 representable for every legal BITS.
    function automatic int cnt_width(input int bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/multiplicador_secuencial_sumador.sv
// Plain BITS-wide ripple-carry adder shared by the sequential multiplier datapath.
// Each stage is a full adder feeding its carry into the next stage.
module sumador #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] s,
    output logic            cout
);

    logic [BITS:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < BITS; i++) begin : g_stage
        assign s[i]         = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[BITS];

endmodule

// File: rtl/multiplicador_secuencial.sv
// Shift-and-add unsigned multiplier: one shared sumador is reused over BITS iterations
// to build a 2*BITS-bit product, with a one-cycle done pulse on completion.
module multiplicador_secuencial
    import multiplicador_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BITS-1:0]   num1,
    input  logic [BITS-1:0]   num2,
    output logic              busy,
    output logic              done,
    output logic [2*BITS-1:0] producto
);

    localparam int            CW   = cnt_width(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    estado_t         state;
    estado_t         next_state;
    logic [BITS-1:0] reg_a;
    logic [BITS-1:0] reg_m;
    logic [BITS-1:0] reg_q;
    logic            reg_c;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] suma;
    logic            cout;
    logic [2*BITS:0] shifted;

    sumador #(
        .BITS(BITS)
    ) u_sumador (
        .a    (reg_a),
        .b    (reg_m),
        .cin  (1'b0),
        .s    (suma),
        .cout (cout)
    );

    // reg_c is always zero between iterations, so the no-add path simply shifts the whole chain.
    always_comb begin
        shifted = '0;
        if (reg_q[0]) begin
            shifted = {cout, suma, reg_q} >> 1;
        end else begin
            shifted = {reg_c, reg_a, reg_q} >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (cnt == LAST) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            CALC:    busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // producto only loads on the final iteration so it stays steady while CALC runs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_a    <= '0;
            reg_m    <= '0;
            reg_q    <= '0;
            reg_c    <= 1'b0;
            cnt      <= '0;
            producto <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        reg_m <= num1;
                        reg_q <= num2;
                        reg_a <= '0;
                        reg_c <= 1'b0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    reg_c <= shifted[2*BITS];
                    reg_a <= shifted[2*BITS-1:BITS];
                    reg_q <= shifted[BITS-1:0];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        producto <= shifted[2*BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
